// File: rtl/pacman_move_ctrl_if.sv
// ---------------------------------------------------------------------------
// pacman_move_ctrl_if
//  Bundles the frame tick, joystick strobe, maze-map lookup handshake and the
//  sprite position outputs of the Pac-Man movement sequencer.
//  modport slave  : the movement sequencer itself
//  modport master : the surrounding system (frame timer, joystick, maze map,
//                   sprite renderer)
//  Signals: ce, joy_valid, joy_dir[1:0]            (system -> sequencer)
//           map_req, map_x[4:0], map_y[4:0]        (sequencer -> maze map)
//           map_ack, map_wall                      (maze map -> sequencer)
//           xpos[4:0], ypos[4:0], direction[1:0],
//           moving, step                           (sequencer -> renderer)
// ---------------------------------------------------------------------------
interface pacman_move_ctrl_if;
  logic       ce;
  logic       joy_valid;
  logic [1:0] joy_dir;
  logic       map_req;
  logic [4:0] map_x;
  logic [4:0] map_y;
  logic       map_ack;
  logic       map_wall;
  logic [4:0] xpos;
  logic [4:0] ypos;
  logic [1:0] direction;
  logic       moving;
  logic       step;

  modport slave (
    input  ce, joy_valid, joy_dir, map_ack, map_wall,
    output map_req, map_x, map_y, xpos, ypos, direction, moving, step
  );

  modport master (
    output ce, joy_valid, joy_dir, map_ack, map_wall,
    input  map_req, map_x, map_y, xpos, ypos, direction, moving, step
  );
endinterface

// File: rtl/pacman_move_ctrl.sv
// ---------------------------------------------------------------------------
// pacman_move_ctrl
//  Movement sequencer for the Pac-Man sprite. Paces tile steps from the frame
//  tick, buffers the latest joystick turn request and probes the target tile
//  through the maze-map handshake before committing a step. A buffered turn
//  is taken as soon as its tile is open; otherwise Pac-Man keeps going
//  straight, or stops at a wall.
//  Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      pacman_move_ctrl_if.slave (tick, joystick, map handshake,
//            xpos/ypos/direction/moving/step outputs)
//  Optional feature: define PACMAN_TUNNEL_WRAP_EN to make the left/right
//  borders a wrap-around tunnel instead of a wall.
//  Directions: 0 up (y-1), 1 left (x-1), 2 down (y+1), 3 right (x+1).
// ---------------------------------------------------------------------------
module pacman_move_ctrl #(
  parameter int MOVE_FRAMES  = 8,
  parameter int START_X      = 14,
  parameter int START_Y      = 23,
  parameter int START_DIR    = 1,
  parameter int BORDER_X_MIN = 1,
  parameter int BORDER_X_MAX = 28,
  parameter int BORDER_Y_MIN = 1,
  parameter int BORDER_Y_MAX = 28
) (
  input logic               clk,
  input logic               reset_n,
  pacman_move_ctrl_if.slave bus
);

  localparam logic [5:0] TICK_LAST = 6'(MOVE_FRAMES - 1);
  localparam logic [4:0] LX_MIN    = 5'(BORDER_X_MIN);
  localparam logic [4:0] LX_MAX    = 5'(BORDER_X_MAX);
  localparam logic [4:0] LY_MIN    = 5'(BORDER_Y_MIN);
  localparam logic [4:0] LY_MAX    = 5'(BORDER_Y_MAX);

  typedef enum logic [1:0] {IDLE, TRY_PEND, TRY_CUR, COMMIT} state_t;

  state_t     r_state;
  logic [5:0] r_tick;
  logic       r_step_due;
  logic       r_pend_valid;
  logic [1:0] r_pend_dir;
  logic [1:0] r_sel_dir;   // direction under test, frozen for the handshake
  logic       r_oob;       // target off the board: no lookup, treat as wall
  logic       r_map_req;
  logic [4:0] r_map_x, r_map_y;
  logic [4:0] r_xpos, r_ypos;
  logic [1:0] r_dir;
  logic       r_moving, r_step;

  // Neighbour tile of (x,y) in direction d, packed as {oob, x, y}.
  // 5-bit wrap of x-1 at x=0 lands above the max border, so it is caught too.
  function automatic logic [10:0] f_tgt(input logic [1:0] d,
                                        input logic [4:0] x, input logic [4:0] y);
    logic [4:0] tx, ty;
    logic       x_out, y_out;
    tx = x;
    ty = y;
    case (d)
      2'd0: ty = y - 5'd1;
      2'd1: tx = x - 5'd1;
      2'd2: ty = y + 5'd1;
      default: tx = x + 5'd1;
    endcase
    x_out = (tx < LX_MIN) || (tx > LX_MAX);
    y_out = (ty < LY_MIN) || (ty > LY_MAX);
`ifdef PACMAN_TUNNEL_WRAP_EN
    // Only a horizontal move can leave the column range; the wrapped tile
    // still goes through a normal map lookup.
    if (x_out) begin
      tx    = (d == 2'd1) ? LX_MAX : LX_MIN;
      x_out = 1'b0;
    end
`endif
    return {x_out | y_out, tx, ty};
  endfunction

  logic [10:0] w_tgt_pend, w_tgt_cur;
  logic        w_expire, w_done;

  assign w_tgt_pend = f_tgt(r_pend_dir, r_xpos, r_ypos);
  assign w_tgt_cur  = f_tgt(r_dir, r_xpos, r_ypos);
  assign w_expire   = bus.ce && (r_tick == TICK_LAST);
  // A TRY state resolves either on its own (off-board) or on an accepted ack.
  assign w_done     = r_oob || (r_map_req && bus.map_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_tick       <= '0;
      r_step_due   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_dir   <= '0;
      r_sel_dir    <= '0;
      r_oob        <= 1'b0;
      r_map_req    <= 1'b0;
      r_map_x      <= '0;
      r_map_y      <= '0;
      r_xpos       <= 5'(START_X);
      r_ypos       <= 5'(START_Y);
      r_dir        <= 2'(START_DIR);
      r_moving     <= 1'b0;
      r_step       <= 1'b0;
    end else begin
      r_step <= 1'b0;

      // Pacing runs in every state; an expiry with step_due already set is lost.
      if (bus.ce) r_tick <= (r_tick == TICK_LAST) ? 6'd0 : r_tick + 6'd1;
      if (w_expire) r_step_due <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_step_due) begin
            r_step_due <= 1'b0;
            if (r_pend_valid) begin
              {r_oob, r_map_x, r_map_y} <= w_tgt_pend;
              r_map_req <= ~w_tgt_pend[10];
              r_sel_dir <= r_pend_dir;
              r_state   <= TRY_PEND;
            end else begin
              {r_oob, r_map_x, r_map_y} <= w_tgt_cur;
              r_map_req <= ~w_tgt_cur[10];
              r_sel_dir <= r_dir;
              r_state   <= TRY_CUR;
            end
          end
        end
        TRY_PEND, TRY_CUR: begin
          if (w_done) begin
            if (!r_oob && !bus.map_wall) begin
              r_xpos    <= r_map_x;
              r_ypos    <= r_map_y;
              r_dir     <= r_sel_dir;
              r_moving  <= 1'b1;
              r_step    <= 1'b1;
              r_map_req <= 1'b0;
              r_state   <= COMMIT;
              if (r_state == TRY_PEND) r_pend_valid <= 1'b0;
            end else if (r_state == TRY_PEND) begin
              // Turn blocked: keep it buffered and fall back to going straight.
              {r_oob, r_map_x, r_map_y} <= w_tgt_cur;
              r_map_req <= ~w_tgt_cur[10];
              r_sel_dir <= r_dir;
              r_state   <= TRY_CUR;
            end else begin
              r_moving  <= 1'b0;
              r_map_req <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;  // COMMIT: step pulse is high this cycle
      endcase

      // After the FSM so a new request beats a same-cycle consumption.
      if (bus.joy_valid && (bus.joy_dir != r_dir)) begin
        r_pend_dir   <= bus.joy_dir;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign bus.map_req   = r_map_req;
  assign bus.map_x     = r_map_x;
  assign bus.map_y     = r_map_y;
  assign bus.xpos      = r_xpos;
  assign bus.ypos      = r_ypos;
  assign bus.direction = r_dir;
  assign bus.moving    = r_moving;
  assign bus.step      = r_step;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
module tb_pacman_move_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pacman_move_ctrl_if bus();

  pacman_move_ctrl #(.MOVE_FRAMES(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Maze model: acks in the first request cycle unless ack_en is held low.
  logic ack_en;
  logic walls [0:31][0:31];
  assign bus.map_ack  = bus.map_req & ack_en;
  assign bus.map_wall = walls[bus.map_x][bus.map_y];

  int n_cmp = 0;
  int n_err = 0;
  int req_cycles = 0;
  int r0;
  logic [31:0] exp_lk[$];
  logic [31:0] exp_st[$];

  function automatic logic [31:0] lk(input int x, input int y);
    return {22'd0, 5'(x), 5'(y)};
  endfunction
  function automatic logic [31:0] st(input int x, input int y, input int d);
    return {20'd0, 5'(x), 5'(y), 2'(d)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted lookup and every step pulse pops an expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.map_req) req_cycles++;
      if (bus.map_req && bus.map_ack)
        chk("lookup", {22'd0, bus.map_x, bus.map_y},
            (exp_lk.size() != 0) ? exp_lk.pop_front() : 32'hFFFF_FFFF);
      if (bus.step)
        chk("step", {20'd0, bus.xpos, bus.ypos, bus.direction},
            (exp_st.size() != 0) ? exp_st.pop_front() : 32'hFFFF_FFFF);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ces(input int n);
    repeat (n) begin
      @(posedge clk); #1 bus.ce = 1'b1;
      @(posedge clk); #1 bus.ce = 1'b0;
    end
  endtask

  task automatic joy(input logic [1:0] d);
    @(posedge clk); #1 bus.joy_valid = 1'b1; bus.joy_dir = d;
    @(posedge clk); #1 bus.joy_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_lk.size() + exp_st.size()) != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    cyc(6);
    chk("drain", 32'(exp_lk.size() + exp_st.size()), 32'd0);
  endtask

  task automatic clear_walls();
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        walls[x][y] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    exp_lk.delete();
    exp_st.delete();
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ce = 1'b0; bus.joy_valid = 1'b0; bus.joy_dir = 2'd0;
    ack_en = 1'b1;
    clear_walls();
    cyc(3);
    chk("rst_xpos",  32'(bus.xpos), 32'd14);
    chk("rst_ypos",  32'(bus.ypos), 32'd23);
    chk("rst_dir",   32'(bus.direction), 32'd1);
    chk("rst_moving", 32'(bus.moving), 32'd0);
    chk("rst_step",  32'(bus.step), 32'd0);
    chk("rst_req",   32'(bus.map_req), 32'd0);
    chk("rst_mapxy", {22'd0, bus.map_x, bus.map_y}, 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Turn right, then keep running right; one step per 4 ticks.
    joy(2'd3);
    exp_lk.push_back(lk(15, 23)); exp_st.push_back(st(15, 23, 3));
    ces(4); settle();
    exp_lk.push_back(lk(16, 23)); exp_st.push_back(st(16, 23, 3));
    ces(3); cyc(6);
    chk("pace_hold", 32'(bus.xpos), 32'd15);
    ces(1); settle();
    chk("pace_x16", 32'(bus.xpos), 32'd16);
    exp_lk.push_back(lk(17, 23)); exp_st.push_back(st(17, 23, 3));
    ces(4); settle();
    chk("run_x17", 32'(bus.xpos), 32'd17);
    chk("run_moving", 32'(bus.moving), 32'd1);

    // Wall straight ahead: one lookup, no step, stops.
    walls[18][23] = 1'b1;
    exp_lk.push_back(lk(18, 23));
    ces(4); settle();
    chk("wall_x", 32'(bus.xpos), 32'd17);
    chk("wall_moving", 32'(bus.moving), 32'd0);

    // Stalled handshake, then async reset drops the request immediately.
    ack_en = 1'b0;
    ces(4); cyc(10);
    chk("stall_req", 32'(bus.map_req), 32'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("arst_req",  32'(bus.map_req), 32'd0);
    chk("arst_xpos", 32'(bus.xpos), 32'd14);
    chk("arst_ypos", 32'(bus.ypos), 32'd23);
    chk("arst_dir",  32'(bus.direction), 32'd1);
    exp_lk.delete(); exp_st.delete();
    cyc(2);
    reset_n = 1'b1;
    ack_en = 1'b1;
    clear_walls();
    cyc(1);

    // Wall to the left at start, no request buffered.
    walls[13][23] = 1'b1;
    exp_lk.push_back(lk(13, 23));
    ces(4); settle();
    chk("wl_xpos", 32'(bus.xpos), 32'd14);
    chk("wl_moving", 32'(bus.moving), 32'd0);
    clear_walls();

    // Newest request overwrites the older one.
    joy(2'd0); joy(2'd2);
    exp_lk.push_back(lk(14, 24)); exp_st.push_back(st(14, 24, 2));
    ces(4); settle();
    chk("ovr_dir", 32'(bus.direction), 32'd2);

    // Blocked turn falls back to straight and stays buffered.
    do_reset();
    exp_lk.push_back(lk(13, 23)); exp_st.push_back(st(13, 23, 1));
    ces(4); settle();
    joy(2'd3);
    exp_lk.push_back(lk(14, 23)); exp_st.push_back(st(14, 23, 3));
    ces(4); settle();
    walls[14][22] = 1'b1;
    joy(2'd0);
    exp_lk.push_back(lk(14, 22)); exp_lk.push_back(lk(15, 23));
    exp_st.push_back(st(15, 23, 3));
    ces(4); settle();
    chk("blk_dir", 32'(bus.direction), 32'd3);
    exp_lk.push_back(lk(15, 22)); exp_st.push_back(st(15, 22, 0));
    ces(4); settle();
    chk("pend_kept_dir", 32'(bus.direction), 32'd0);

    // Left border.
    do_reset();
    clear_walls();
    for (int x = 13; x >= 1; x--) begin
      exp_lk.push_back(lk(x, 23)); exp_st.push_back(st(x, 23, 1));
      ces(4); settle();
    end
    chk("edge_x1", 32'(bus.xpos), 32'd1);
    r0 = req_cycles;
`ifdef PACMAN_TUNNEL_WRAP_EN
    exp_lk.push_back(lk(28, 23)); exp_st.push_back(st(28, 23, 1));
    ces(4); settle();
    chk("wrap_x", 32'(bus.xpos), 32'd28);
`else
    ces(4); settle();
    chk("border_noreq", 32'(req_cycles - r0), 32'd0);
    chk("border_x", 32'(bus.xpos), 32'd1);
    chk("border_moving", 32'(bus.moving), 32'd0);
`endif

    // Bottom border is a wall in every build.
    do_reset();
    joy(2'd2);
    for (int y = 24; y <= 28; y++) begin
      exp_lk.push_back(lk(14, y)); exp_st.push_back(st(14, y, 2));
      ces(4); settle();
    end
    r0 = req_cycles;
    ces(4); settle();
    chk("vborder_noreq", 32'(req_cycles - r0), 32'd0);
    chk("vborder_y", 32'(bus.ypos), 32'd28);
    chk("vborder_moving", 32'(bus.moving), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
